// File: rtl/jk_pkg.sv
// Shared types for the J-K excitation driver: FSM states, {J,K} command
// encoding and the per-bit excitation rule.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Bit order is {J,K}.
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_t;

  localparam int unsigned ERR_COUNT_MAX = 255;

  // Don't-cares in the excitation table resolve to 0, so holds are always 00.
  function automatic jk_cmd_t excite(input logic q, input logic target,
                                     input logic use_toggle);
    jk_cmd_t cmd;
    if (q == target)
      cmd = HOLD;
    else if (use_toggle)
      cmd = TOGGLE;
    else if (target)
      cmd = SET;
    else
      cmd = RESET;
    return cmd;
  endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// Combinational per-bit excitation: current Q and target Q to J/K.
module jk_excite_cell
  import jk_pkg::*;
(
  input  logic q,
  input  logic target,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  jk_cmd_t cmd;

  always_comb begin
    cmd    = excite(q, target, use_toggle);
    {j, k} = cmd;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external J-K flip-flop bank towards a target word, then compares
// the bank's Q after a settle period and reports done/mismatch.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          USE_TOGGLE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_excite_cell u_cell (
      .q         (q_in[i]),
      .target    (tgt_data[i]),
      .use_toggle(USE_TOGGLE),
      .j         (j_next[i]),
      .k         (k_next[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      target     <= '0;
      tgt_ready  <= 1'b1;
      j_out      <= '0;
      k_out      <= '0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            target    <= tgt_data;
            j_out     <= j_next;
            k_out     <= k_next;
            tgt_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          j_out      <= '0;
          k_out      <= '0;
          settle_cnt <= '0;
          state      <= CHECK;
        end
        CHECK: begin
          if (settle_cnt == SETTLE_LAST) begin
            done      <= 1'b1;
            mismatch  <= (q_in != target);
            tgt_ready <= 1'b1;
            state     <= IDLE;
            if ((q_in != target) && (err_count != 8'(ERR_COUNT_MAX)))
              err_count <= err_count + 8'd1;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: begin
          tgt_ready <= 1'b1;
          j_out     <= '0;
          k_out     <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: two drivers (set/reset settle 1, toggle settle 3), each
// with a behavioural J-K bank; expected completions are queued at issue.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic       mm;
    logic [7:0] err;
    logic [3:0] q;
    int         at;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  // Instance A: USE_TOGGLE=0, SETTLE_CYCLES=1
  logic       valid_a, ready_a, done_a, mm_a;
  logic [3:0] data_a, bank_a, j_a, k_a, ld_val_a, stuck_a;
  logic [7:0] err_a;
  logic       ld_a;
  // Instance B: USE_TOGGLE=1, SETTLE_CYCLES=3
  logic       valid_b, ready_b, done_b, mm_b;
  logic [3:0] data_b, bank_b, j_b, k_b, ld_val_b;
  logic [7:0] err_b;
  logic       ld_b;

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYCLES(1), .USE_TOGGLE(1'b0)) u_a (
    .clk(clk), .reset(reset), .tgt_valid(valid_a), .tgt_ready(ready_a),
    .tgt_data(data_a), .q_in(bank_a), .j_out(j_a), .k_out(k_a),
    .done(done_a), .mismatch(mm_a), .err_count(err_a));

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYCLES(3), .USE_TOGGLE(1'b1)) u_b (
    .clk(clk), .reset(reset), .tgt_valid(valid_b), .tgt_ready(ready_b),
    .tgt_data(data_b), .q_in(bank_b), .j_out(j_b), .k_out(k_b),
    .done(done_b), .mismatch(mm_b), .err_count(err_b));

  // Behavioural banks (no reset); stuck_a forces bits of bank A to 0.
  always @(posedge clk) begin
    if (ld_a) bank_a <= ld_val_a & ~stuck_a;
    else      bank_a <= ((j_a & ~bank_a) | (~k_a & bank_a)) & ~stuck_a;
    if (ld_b) bank_b <= ld_val_b;
    else      bank_b <= (j_b & ~bank_b) | (~k_b & bank_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Called at the negedge just before the accepting edge.
  task automatic expect_txn(input bit which, input logic mm, input logic [7:0] err,
                            input logic [3:0] q, input int settle);
    exp_t e;
    e.mm = mm; e.err = err; e.q = q; e.at = cyc + settle + 2;
    if (which) exp_b.push_back(e);
    else       exp_a.push_back(e);
  endtask

  task automatic send(input bit which, input logic [3:0] d);
    if (which) begin valid_b = 1'b1; data_b = d; end
    else       begin valid_a = 1'b1; data_a = d; end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic load(input bit which, input logic [3:0] v);
    if (which) begin ld_b = 1'b1; ld_val_b = v; end
    else       begin ld_a = 1'b1; ld_val_a = v; end
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  task automatic drain(input bit which, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which ? exp_b.size() : exp_a.size()) == 0) return;
    end
    flag(which ? "drain_timeout_b" : "drain_timeout_a");
  endtask

  // Monitors
  always @(negedge clk) begin
    if (mm_a && !done_a) flag("mismatch_without_done_a");
    if (done_a) begin
      if (exp_a.size() == 0) flag("spurious_done_a");
      else begin
        exp_t e;
        e = exp_a.pop_front();
        check("done_cycle_a", cyc, e.at);
        check("mismatch_a", mm_a, e.mm);
        check("err_count_a", err_a, e.err);
        check("bank_q_a", bank_a, e.q);
        check("ready_with_done_a", ready_a, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (mm_b && !done_b) flag("mismatch_without_done_b");
    if (done_b) begin
      if (exp_b.size() == 0) flag("spurious_done_b");
      else begin
        exp_t e;
        e = exp_b.pop_front();
        check("done_cycle_b", cyc, e.at);
        check("mismatch_b", mm_b, e.mm);
        check("err_count_b", err_b, e.err);
        check("bank_q_b", bank_b, e.q);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    valid_a = 1'b0; data_a = '0; ld_a = 1'b0; ld_val_a = '0; stuck_a = '0;
    valid_b = 1'b0; data_b = '0; ld_b = 1'b0; ld_val_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle hold
    check("reset_ready_a", ready_a, 1'b1);
    check("reset_j_a", j_a, 4'b0000);
    check("reset_k_a", k_a, 4'b0000);
    check("reset_err_a", err_a, 8'd0);
    check("reset_ready_b", ready_b, 1'b1);
    check("reset_err_b", err_b, 8'd0);
    load(1'b0, 4'b0011);
    load(1'b1, 4'b1111);
    repeat (5) @(negedge clk);

    // Set/reset excitation: 0011 -> 0101
    expect_txn(1'b0, 1'b0, 8'd0, 4'b0101, 1);
    send(1'b0, 4'b0101);
    check("drive_j_a", j_a, 4'b0100);
    check("drive_k_a", k_a, 4'b0010);
    check("drive_ready_a", ready_a, 1'b0);
    drain(1'b0, 20);

    // Toggle excitation: 1111 -> 0000
    expect_txn(1'b1, 1'b0, 8'd0, 4'b0000, 3);
    send(1'b1, 4'b0000);
    check("drive_j_b", j_b, 4'b1111);
    check("drive_k_b", k_b, 4'b1111);
    @(negedge clk);
    check("check_j_b", j_b, 4'b0000);
    check("check_k_b", k_b, 4'b0000);
    drain(1'b1, 20);

    // Stuck-at-0 bit 0: repeated mismatches saturate err_count
    stuck_a = 4'b0001;
    load(1'b0, 4'b0000);
    for (int i = 1; i <= 300; i++) begin
      expect_txn(1'b0, 1'b1, (i > 255) ? 8'd255 : 8'(i), 4'b0000, 1);
      send(1'b0, 4'b0001);
      drain(1'b0, 20);
    end
    stuck_a = 4'b0000;

    // Back-to-back with tgt_valid held: accepts at n, n+3, n+6
    begin
      int n;
      n = cyc;
      exp_a.push_back('{mm: 1'b0, err: 8'd255, q: 4'hA, at: n + 3});
      exp_a.push_back('{mm: 1'b0, err: 8'd255, q: 4'h5, at: n + 6});
      exp_a.push_back('{mm: 1'b0, err: 8'd255, q: 4'hF, at: n + 9});
      valid_a = 1'b1; data_a = 4'hA;
      @(negedge clk);
      data_a = 4'h5;
      repeat (3) @(negedge clk);
      data_a = 4'hF;
      repeat (3) @(negedge clk);
      valid_a = 1'b0;
      drain(1'b0, 20);
    end

    // Asynchronous reset in the middle of CHECK abandons the operation
    send(1'b1, 4'b0110);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_ready_b", ready_b, 1'b1);
    check("midreset_j_b", j_b, 4'b0000);
    check("midreset_done_b", done_b, 1'b0);
    check("midreset_err_a", err_a, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    expect_txn(1'b1, 1'b0, 8'd0, 4'b0011, 3);
    send(1'b1, 4'b0011);
    check("post_reset_j_b", j_b, 4'b0101);
    drain(1'b1, 20);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives the J/K inputs of an external bank of WIDTH J-K flip-flops so that the bank's Q reaches a requested target word, then checks the result. It is the stimulus side of the J-K flip-flop interface: each target arrives on a valid/ready handshake, J/K are derived from the excitation table using the bank's current Q, and a done/mismatch report is produced. It sits between a pattern source and the flip-flop bank under exercise, sharing that bank's clock.

## Interface
- WIDTH, 4, number of J-K flip-flops driven (1..32)
- SETTLE_CYCLES, 1, clocks waited after the drive edge before Q is compared (1..15)
- USE_TOGGLE, 0, 0: drive transitions with set/reset (J=1,K=0 / J=0,K=1); 1: drive transitions with toggle (J=K=1)
- clk  input  1  single clock, rising edge; also clocks the flip-flop bank
- reset  input  1  asynchronous, active-high reset
- tgt_valid  input  1  target word offered
- tgt_ready  output  1  block can accept a target
- tgt_data  input  WIDTH  requested Q value
- q_in  input  WIDTH  current Q of the flip-flop bank
- j_out  output  WIDTH  J inputs of the bank
- k_out  output  WIDTH  K inputs of the bank
- done  output  1  one-cycle pulse: target processed
- mismatch  output  1  one-cycle pulse coincident with done: q_in differed from target
- err_count  output  8  saturating count of mismatches

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1, j_out=k_out=0. On a rising edge with tgt_valid=1, latch tgt_data, compute per-bit J/K from q_in sampled at that edge, register them, go to DRIVE.
- Excitation per bit, with USE_TOGGLE=0: Q 0->0 J=0,K=0; 0->1 J=1,K=0; 1->0 J=0,K=1; 1->1 J=0,K=0. With USE_TOGGLE=1 the hold cases are unchanged and both transitions use J=1,K=1. Don't-cares always resolve to 0.
- DRIVE: lasts exactly one cycle; j_out/k_out hold the registered values; tgt_ready=0. At the edge that ends DRIVE the bank updates. Then j_out=k_out=0 and go to CHECK.
- CHECK: tgt_ready=0, j_out=k_out=0 (hold). Count SETTLE_CYCLES edges. On the final edge, compare q_in with the latched target, register done=1 and mismatch=(q_in!=target), increment err_count on mismatch (saturate at 255), go to IDLE.
- tgt_data need only be valid on the handshake edge; changes during DRIVE/CHECK are ignored.
- The bank has no reset, so the first target's J/K use whatever q_in is at acceptance. That value is treated as valid.

## Timing
- Reset values: state IDLE, tgt_ready=1, j_out=0, k_out=0, done=0, mismatch=0, err_count=0, latched target=0.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). The operation in progress is abandoned without done.
- Reset and tgt_valid together: reset wins, nothing is accepted.
- Latency: accept edge E0; J/K visible during cycle E0..E1; bank updates at E1; compare at E1+SETTLE_CYCLES; done/mismatch high for the cycle after that edge.
- done and tgt_ready are both high in that cycle, so a new target may be accepted on the next edge. Throughput is one target per SETTLE_CYCLES+2 cycles.
- err_count updates on the same edge that raises mismatch.

## Structure
- Shared package jk_pkg holds: the state enum (IDLE, DRIVE, CHECK), the 2-bit jk_cmd_t encoding {J,K} (HOLD=00, RESET=01, SET=10, TOGGLE=11), and ERR_COUNT_MAX=255.
- One sub-module, jk_excite_cell: a combinational per-bit mapping (q, target, use_toggle) -> (j, k), instantiated WIDTH times via generate.
- The top level contains the FSM, the settle counter, the target/J/K registers and the compare/err_count logic.

## Test plan
- Reset then hold: after reset, j_out=0, k_out=0, tgt_ready=1, err_count=0, and done never rises with tgt_valid=0.
- Basic set/reset with a behavioural JK bank, USE_TOGGLE=0, bank Q=4'b0011, target 4'b0101: DRIVE cycle shows j_out=4'b0100 and k_out=4'b0010; done after 3 edges; mismatch=0; Q=4'b0101.
- Toggle mode, USE_TOGGLE=1, Q=4'b1111, target 4'b0000: j_out=k_out=4'b1111 for one cycle; Q=4'b0000; done=1; mismatch=0.
- Fault injection: bank bit 0 stuck at 0, target 4'b0001: mismatch=1 with done, err_count=1. Repeat 300 times: err_count saturates at 255.
- Back-to-back: tgt_valid held high with targets 4'hA, 4'h5, 4'hF: each accepted on the edge after its done, 3 done pulses, all with mismatch=0.
- Reset during CHECK with SETTLE_CYCLES=3: asynchronous reset mid-CHECK clears outputs at once, no done pulse; the next target completes normally.
